// File: rtl/srp_peak_search.sv
// Read-side peak search over the SRP correlation buffer: sweeps BRAM addresses 0..len-1 and
// tracks the largest sample and its address. Define PEAK_ABS_EN to compare sample magnitudes.
module srp_peak_search #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2097
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        len,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  input  logic signed [DATA_W-1:0] bram_dout,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0]        peak_idx,
  output logic [1:0]               state_dbg
);

  // Handshake: start is honoured only in IDLE; done pulses one cycle and results hold afterwards.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDR_W-1:0]          r_addr;
  logic [ADDR_W-1:0]          r_len;
  logic [ADDR_W-1:0]          r_idx_d;
  logic                       r_vld;
  logic                       r_have;
  logic [ADDR_W-1:0]          w_len_eff;
  logic                       w_start_ok;
  logic                       w_last;
  logic signed [DATA_W-1:0]   w_sample;

  assign w_len_eff  = (len > DEPTH_A) ? DEPTH_A : len;
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_last     = (r_addr == (r_len - ADDR_W'(1)));

  assign bram_we   = 1'b0;
  assign bram_addr = r_addr;
  assign state_dbg = r_state;

`ifdef PEAK_ABS_EN
  localparam logic signed [DATA_W-1:0] MIN_S = {1'b1, {(DATA_W-1){1'b0}}};

  // The most negative value has no positive twin, so it saturates to the largest positive value.
  always_comb begin
    if (bram_dout == MIN_S) begin
      w_sample = ~MIN_S;
    end else if (bram_dout[DATA_W-1]) begin
      w_sample = -bram_dout;
    end else begin
      w_sample = bram_dout;
    end
  end
`else
  assign w_sample = bram_dout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    bram_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (w_len_eff == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        bram_en = 1'b1;
        busy    = 1'b1;
        if (w_last) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_vld/r_idx_d shadow the BRAM's one-cycle read latency; r_have marks that a first sample is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_idx_d  <= '0;
      r_vld    <= 1'b0;
      r_have   <= 1'b0;
      peak_val <= '0;
      peak_idx <= '0;
    end else begin
      r_vld   <= bram_en;
      r_idx_d <= r_addr;
      if (w_start_ok) begin
        r_len  <= w_len_eff;
        r_addr <= '0;
        r_have <= 1'b0;
        if (w_len_eff == '0) begin
          peak_val <= '0;
          peak_idx <= '0;
        end
      end else if (bram_en && !w_last) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      // Strictly-greater replacement keeps the lowest address on ties.
      if (r_vld) begin
        r_have <= 1'b1;
        if (!r_have || (w_sample > peak_val)) begin
          peak_val <= w_sample;
          peak_idx <= r_idx_d;
        end
      end
    end
  end

endmodule

// File: doc/srp_peak_search.md
Name: srp_peak_search

Overview:
- Read-side controller placed directly downstream of the Shapiro-Rudin-Park correlation buffer BRAM.
- After the buffer is filled, a start pulse makes the block sweep addresses 0..len-1 through the BRAM's single port and track the largest sample value and its address.
- The resulting peak index is the timing offset used by the time synchronizer.
- Read-only master: never writes the BRAM.

Parameters:
- ADDR_W, 12, BRAM address width.
- DATA_W, 32, signed sample width.
- DEPTH, 2097, number of valid BRAM words; addresses 0..DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE.
- len  in  ADDR_W  number of words to scan; sampled on an accepted start.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable; constant 0.
- bram_addr  out  ADDR_W  BRAM address.
- bram_dout  in  DATA_W  signed BRAM read data; 1-cycle registered latency.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- peak_val  out  DATA_W  signed peak value (magnitude if PEAK_ABS_EN).
- peak_idx  out  ADDR_W  address of the peak.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, and takes priority over every other input.
- Reset values: bram_en=0, bram_we=0, bram_addr=0, busy=0, done=0, peak_val=0, peak_idx=0, state=IDLE.
- State IDLE:
  - start=1 captures len_eff = min(len, DEPTH).
  - If len_eff=0, go to DONE with peak_val=0 and peak_idx=0.
  - Otherwise go to READ, set addr counter=0, and clear the first-sample flag.
- State READ:
  - bram_en=1, bram_addr=counter; the counter increments each cycle.
  - After issuing address len_eff-1, go to FLUSH. bram_en drops to 0 in FLUSH.
- Data pipeline:
  - A 1-bit valid shadow of bram_en, delayed one cycle, marks when bram_dout holds the data for address idx_d (addr delayed one cycle).
  - On each valid cycle: the first sample loads unconditionally. Each later sample replaces the peak only if it is strictly greater, so on ties the lowest address wins.
- State FLUSH: lasts one cycle while the last sample is compared, then go to DONE.
- State DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Result hold: peak_val and peak_idx hold until the next accepted start. They are not cleared at start and change only during the sweep.
- Latency: an accepted start at cycle 0 gives address 0 at cycle 1, address len_eff-1 at cycle len_eff, and done at cycle len_eff+2. For len_eff=0, done is at cycle 1.
- busy: 1 in READ and FLUSH only.
- start during busy or DONE: ignored, with no queueing.
- len > DEPTH: clamped to DEPTH, so the highest address issued is DEPTH-1.
- rst mid-sweep: abandons the sweep next edge; all outputs return to reset values; no done pulse.
- bram_addr in IDLE: holds its last value. bram_en=0 makes it don't-care.

Optional Feature:
- Macro: PEAK_ABS_EN.
- Defined:
  - The comparison uses the magnitude of each sample.
  - -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - peak_val reports that non-negative magnitude.
  - Suits correlators whose sign is arbitrary.
- Undefined:
  - Plain signed comparison; peak_val is the raw signed sample.
- Latency and ports are identical in both builds.

Test Plan:
- Sweep: BRAM preloaded with addr*3 - 100, len=10, start pulse at cycle 0 -> addresses 0..9 on cycles 1..10, done at cycle 12, peak_val=-73, peak_idx=9, busy high on cycles 1..11.
- Ties and signed compare: preload [5, 9, -20, 9, 2], len=5 -> peak_val=9, peak_idx=1. With PEAK_ABS_EN -> peak_val=20, peak_idx=2.
- Boundaries:
  - len=0 -> done at cycle 1, peak_val=0, peak_idx=0, bram_en never asserted.
  - len=4095 -> last address issued is 2096, done at cycle 2099.
- Saturation: preload [-2147483648, 100], len=2, PEAK_ABS_EN -> peak_val=2147483647, peak_idx=0. Without PEAK_ABS_EN -> peak_val=100, peak_idx=1.
- Start while busy: second start at cycle 3 of a len=10 sweep -> ignored; single done at cycle 12; results match a single sweep.
- Reset mid-sweep: rst at cycle 5 of a len=10 sweep -> cycle 6 shows all outputs zero and state IDLE, no done pulse; a fresh start completes normally with len+2 latency.
